solve_sequencer: RTL and testbench



---
 rtl/nonogram_pkg.sv | 21 ++
 rtl/clue_store.sv | 22 ++
 rtl/solve_sequencer.sv | 162 ++++++++++++++++
 tb/tb_solve_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonogram_pkg.sv
// Shared types and sizing for the nonogram solve datapath.
package nonogram_pkg;

  localparam int MAX_DIM   = 11;
  localparam int CLUE_W    = 16;
  localparam int MAX_LINES = 2 * MAX_DIM;

  typedef logic [CLUE_W-1:0] clue_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    DISPATCH = 3'd2,
    WAIT     = 3'd3,
    PASS_END = 3'd4,
    EMIT     = 3'd5,
    XMIT     = 3'd6,
    FAIL     = 3'd7
  } seq_state_t;

endpackage

// File: rtl/clue_store.sv
// Per-line clue register file: one synchronous write port, one combinational read port.
module clue_store
  import nonogram_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] waddr,
  input  clue_t      wdata,
  input  logic [4:0] raddr,
  output clue_t      rdata
);

  // Contents need no reset: every entry is rewritten during LOAD before it is read.
  clue_t mem [MAX_LINES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/solve_sequencer.sv
// Board-level controller: loads clues from the FIFO, dispatches lines to the shared
// line solver pass after pass, then starts the assembler or reports failure.
module solve_sequencer
  import nonogram_pkg::*;
#(
  parameter int MAX_PASSES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        board_done,
  input  logic [3:0]  n,
  input  logic [3:0]  m,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic        ls_valid,
  input  logic        ls_ready,
  output logic [3:0]  ls_idx,
  output logic        ls_is_col,
  output logic [15:0] ls_clue,
  input  logic        ls_done,
  input  logic        ls_changed,
  input  logic        board_solved,
  output logic        asm_valid,
  input  logic        asm_done,
  output logic        busy,
  output logic        fail,
  output logic [5:0]  pass_cnt,
  output logic [2:0]  state_dbg
);

  seq_state_t state, next_state;

  logic [3:0] n_q;
  logic [4:0] total, issued, recv, ptr;
  logic       rd_pending, pass_dirty;
  clue_t      rd_clue;

  logic bad_dims, line_is_col, last_line, pass_limit;

  assign bad_dims    = (n == 4'd0) || (m == 4'd0) ||
                       (n > 4'(MAX_DIM)) || (m > 4'(MAX_DIM));
  assign line_is_col = (ptr >= {1'b0, n_q});
  assign last_line   = (ptr == total - 5'd1);
  assign pass_limit  = (({1'b0, pass_cnt} + 7'd1) == 7'(MAX_PASSES));

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // FIFO data is valid the cycle after the pop, so the write trails rd_en by one.
  clue_store u_store (
    .clk   (clk),
    .we    (rd_pending),
    .waddr (recv),
    .wdata (fifo_dout),
    .raddr (ptr),
    .rdata (rd_clue)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Line-solver handshake: ls_valid with ls_idx/ls_is_col/ls_clue stays asserted and
  // stable in DISPATCH until ls_ready; the request transfers on the cycle both are high.
  always_comb begin
    next_state = state;
    fifo_rd_en = 1'b0;
    ls_valid   = 1'b0;
    ls_idx     = 4'd0;
    ls_is_col  = 1'b0;
    ls_clue    = '0;
    asm_valid  = 1'b0;
    case (state)
      IDLE, FAIL: begin
        if (board_done) next_state = bad_dims ? FAIL : LOAD;
      end
      LOAD: begin
        fifo_rd_en = !fifo_empty && (issued < total);
        if (recv == total) next_state = DISPATCH;
      end
      DISPATCH: begin
        ls_valid  = 1'b1;
        ls_is_col = line_is_col;
        ls_idx    = line_is_col ? 4'(ptr - {1'b0, n_q}) : ptr[3:0];
        ls_clue   = rd_clue;
        if (ls_ready) next_state = WAIT;
      end
      WAIT: begin
        if (ls_done) next_state = last_line ? PASS_END : DISPATCH;
      end
      PASS_END: begin
        if (board_solved)                  next_state = EMIT;
        else if (!pass_dirty || pass_limit) next_state = FAIL;
        else                               next_state = DISPATCH;
      end
      EMIT: begin
        asm_valid  = 1'b1;
        next_state = XMIT;
      end
      XMIT: begin
        if (asm_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= 4'd0;
      total      <= 5'd0;
      issued     <= 5'd0;
      recv       <= 5'd0;
      ptr        <= 5'd0;
      rd_pending <= 1'b0;
      pass_dirty <= 1'b0;
      pass_cnt   <= 6'd0;
      fail       <= 1'b0;
    end else begin
      rd_pending <= fifo_rd_en;
      if (fifo_rd_en) issued <= issued + 5'd1;
      if (rd_pending) recv   <= recv + 5'd1;
      case (state)
        IDLE, FAIL: begin
          if (board_done) begin
            n_q        <= n;
            total      <= {1'b0, n} + {1'b0, m};
            issued     <= 5'd0;
            recv       <= 5'd0;
            ptr        <= 5'd0;
            pass_dirty <= 1'b0;
            pass_cnt   <= 6'd0;
            fail       <= bad_dims;
          end
        end
        LOAD: begin
          if (recv == total) ptr <= 5'd0;
        end
        WAIT: begin
          if (ls_done) begin
            pass_dirty <= pass_dirty | ls_changed;
            if (!last_line) ptr <= ptr + 5'd1;
          end
        end
        PASS_END: begin
          if (pass_cnt != 6'd63) pass_cnt <= pass_cnt + 6'd1;
          if (!board_solved) begin
            if (!pass_dirty || pass_limit) begin
              fail <= 1'b1;
            end else begin
              pass_dirty <= 1'b0;
              ptr        <= 5'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_solve_sequencer.sv
// Directed bench for solve_sequencer with a FIFO model, a line-solver model and
// a dispatch scoreboard.
module tb_solve_sequencer;
  import nonogram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        board_done;
  logic [3:0]  n, m;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en;
  logic        ls_valid;
  logic        ls_ready;
  logic [3:0]  ls_idx;
  logic        ls_is_col;
  logic [15:0] ls_clue;
  logic        ls_done;
  logic        ls_changed;
  logic        board_solved;
  logic        asm_valid;
  logic        asm_done;
  logic        busy;
  logic        fail;
  logic [5:0]  pass_cnt;
  logic [2:0]  state_dbg;

  solve_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .board_done   (board_done),
    .n            (n),
    .m            (m),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_rd_en   (fifo_rd_en),
    .ls_valid     (ls_valid),
    .ls_ready     (ls_ready),
    .ls_idx       (ls_idx),
    .ls_is_col    (ls_is_col),
    .ls_clue      (ls_clue),
    .ls_done      (ls_done),
    .ls_changed   (ls_changed),
    .board_solved (board_solved),
    .asm_valid    (asm_valid),
    .asm_done     (asm_done),
    .busy         (busy),
    .fail         (fail),
    .pass_cnt     (pass_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- models ----------------
  logic [15:0] fifo_mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  logic [20:0] disp_q [$];
  logic [20:0] exp_q  [$];
  int cyc = 0, pop_cnt = 0, empty_pops = 0, asm_cnt = 0;
  int last_pop_cyc = 0, first_valid_cyc = -1;
  int timer = 0, done_cnt = 0, solve_after = 1000, changed_until = 100000;
  bit model_clr = 1'b0;

  initial begin
    ls_done      = 1'b0;
    ls_changed   = 1'b0;
    board_solved = 1'b0;
    fifo_dout    = 16'h0;
  end

  always @(posedge clk) begin
    cyc++;
    ls_done <= 1'b0;
    if (model_clr) begin
      board_solved <= 1'b0;
      ls_changed   <= 1'b0;
      timer     = 0;
      done_cnt  = 0;
      model_clr = 1'b0;
    end else if (ls_valid && ls_ready) begin
      disp_q.push_back({ls_is_col, ls_idx, ls_clue});
      timer = 2;
    end else if (timer > 0) begin
      timer--;
      if (timer == 0) begin
        ls_done    <= 1'b1;
        ls_changed <= (done_cnt < changed_until);
        done_cnt++;
        if (done_cnt == solve_after) board_solved <= 1'b1;
      end
    end
    if (ls_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (asm_valid) asm_cnt++;
    if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) empty_pops++;
      else begin
        fifo_dout <= fifo_mem[rd_ptr[5:0]];
        rd_ptr    <= rd_ptr + 1;
      end
      pop_cnt++;
      last_pop_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clr_model();
    model_clr = 1'b1;
    tick(1);
    disp_q.delete();
    exp_q.delete();
    pop_cnt = 0; empty_pops = 0; asm_cnt = 0; first_valid_cyc = -1;
    solve_after = 1000; changed_until = 100000;
  endtask

  task automatic pulse_board(input logic [3:0] nn, input logic [3:0] mm);
    n = nn; m = mm; board_done = 1'b1;
    tick(1);
    board_done = 1'b0;
  endtask

  task automatic wait_asm(input string tag, input int budget);
    for (int i = 0; i < budget && asm_cnt == 0; i++) tick(1);
    chk(tag, asm_cnt, 1);
  endtask

  task automatic finish_xmit();
    asm_done = 1'b1;
    tick(1);
    asm_done = 1'b0;
    chk("busy_after_asm_done", busy, 0);
  endtask

  task automatic check_disp(input string tag);
    chk({tag, "_count"}, disp_q.size(), exp_q.size());
    while (exp_q.size() > 0 && disp_q.size() > 0)
      chk(tag, disp_q.pop_front(), exp_q.pop_front());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; board_done = 1'b0; n = 4'd0; m = 4'd0;
    ls_ready = 1'b1; asm_done = 1'b0;
    tick(3);
    chk("reset_outputs", {busy, fail, pass_cnt, asm_valid, ls_valid, fifo_rd_en}, 0);
    rst_n = 1'b1;
    tick(2);

    // one-pass solve, 2x2
    clr_model();
    for (int i = 1; i <= 4; i++) push(16'(i));
    solve_after = 4;
    pulse_board(4'd2, 4'd2);
    chk("busy_after_start", busy, 1);
    wait_asm("t1_asm", 200);
    tick(3);
    chk("t1_asm_once", asm_cnt, 1);
    chk("t1_xmit_state", state_dbg, 3'(XMIT));
    chk("t1_pass_cnt", pass_cnt, 1);
    chk("t1_pops", pop_cnt, 4);
    exp_q.push_back({1'b0, 4'd0, 16'h0001});
    exp_q.push_back({1'b0, 4'd1, 16'h0002});
    exp_q.push_back({1'b1, 4'd0, 16'h0003});
    exp_q.push_back({1'b1, 4'd1, 16'h0004});
    check_disp("t1_disp");
    finish_xmit();

    // 11x11 with a slow FIFO
    clr_model();
    solve_after = 22;
    pulse_board(4'd11, 4'd11);
    for (int i = 0; i < 22; i++) begin
      tick(5);
      push(16'h0100 + 16'(i));
    end
    wait_asm("t2_asm", 600);
    chk("t2_pops", pop_cnt, 22);
    chk("t2_empty_pops", empty_pops, 0);
    chk("t2_dispatch_after_load", (first_valid_cyc - last_pop_cyc) >= 3, 1);
    chk("t2_disp_count", disp_q.size(), 22);
    if (disp_q.size() == 22) begin
      chk("t2_first", disp_q[0],  {1'b0, 4'd0,  16'h0100});
      chk("t2_row10", disp_q[10], {1'b0, 4'd10, 16'h010A});
      chk("t2_col0",  disp_q[11], {1'b1, 4'd0,  16'h010B});
      chk("t2_last",  disp_q[21], {1'b1, 4'd10, 16'h0115});
    end
    finish_xmit();

    // stuck puzzle, 3x3: progress in pass 1 only
    clr_model();
    for (int i = 0; i < 6; i++) push(16'h0200 + 16'(i));
    changed_until = 6;
    pulse_board(4'd3, 4'd3);
    for (int i = 0; i < 400 && fail !== 1'b1; i++) tick(1);
    chk("t3_fail", fail, 1);
    chk("t3_pass_cnt", pass_cnt, 2);
    chk("t3_state", state_dbg, 3'(FAIL));
    chk("t3_lines", disp_q.size(), 12);
    tick(3);
    chk("t3_no_asm", asm_cnt, 0);

    // pass limit, 1x1, always changing
    clr_model();
    push(16'h0301); push(16'h0302);
    pulse_board(4'd1, 4'd1);
    chk("t4_fail_cleared", fail, 0);
    chk("t4_pass_cleared", pass_cnt, 0);
    for (int i = 0; i < 2000 && fail !== 1'b1; i++) tick(1);
    chk("t4_fail", fail, 1);
    chk("t4_pass_cnt", pass_cnt, 32);
    chk("t4_lines", disp_q.size(), 64);
    chk("t4_no_asm", asm_cnt, 0);

    // backpressure, 1x1
    clr_model();
    ls_ready = 1'b0;
    push(16'hABCD); push(16'h1234);
    solve_after = 2;
    pulse_board(4'd1, 4'd1);
    for (int i = 0; i < 50 && ls_valid !== 1'b1; i++) tick(1);
    for (int k = 0; k < 7; k++) begin
      chk("t5_hold", {ls_valid, ls_is_col, ls_idx, ls_clue}, {1'b1, 1'b0, 4'd0, 16'hABCD});
      tick(1);
    end
    chk("t5_no_transfer", disp_q.size(), 0);
    ls_ready = 1'b1;
    tick(1);
    chk("t5_transfer", disp_q.size(), 1);
    chk("t5_wait", state_dbg, 3'(WAIT));
    wait_asm("t5_asm", 100);
    exp_q.push_back({1'b0, 4'd0, 16'hABCD});
    exp_q.push_back({1'b1, 4'd0, 16'h1234});
    check_disp("t5_disp");
    finish_xmit();

    // reset in WAIT
    clr_model();
    push(16'h0401); push(16'h0402);
    solve_after = 1;
    pulse_board(4'd1, 4'd1);
    for (int i = 0; i < 50 && state_dbg !== 3'(WAIT); i++) tick(1);
    chk("t6_in_wait", state_dbg, 3'(WAIT));
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs",
        {busy, fail, pass_cnt, asm_valid, ls_valid, fifo_rd_en, ls_idx, ls_is_col, ls_clue}, 0);
    tick(1);
    rst_n = 1'b1;
    tick(30);
    chk("t6_no_asm", asm_cnt, 0);
    chk("t6_idle", busy, 0);

    // bad dimensions
    clr_model();
    push(16'h0501); push(16'h0502);
    pulse_board(4'd0, 4'd5);
    tick(10);
    chk("t7_fail", fail, 1);
    chk("t7_state", state_dbg, 3'(FAIL));
    chk("t7_no_pops", pop_cnt, 0);
    wr_ptr = rd_ptr;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
